// File: rtl/db_pkg.sv
// Shared types for the tick-based input debouncer.
`timescale 1ns/1ps
package db_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // Debounced level seen from outside: high once ONE is reached, until ZERO is re-entered.
    function automatic logic level_of(input db_state_t s);
        return (s == ONE) || (s == WAIT0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin input; both flops clear on reset.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tick_debouncer.sv
// Debounces one raw switch input against the clock-enable tick; clean level plus edge pulses.
// Optional DB_FALL_TICK_EN adds the db_fall port and its one-cycle release pulse.
`timescale 1ns/1ps
module tick_debouncer
    import db_pkg::*;
#(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise
`ifdef DB_FALL_TICK_EN
    ,
    output logic db_fall
`endif
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    generate
        if (STABLE_TICKS < 1) begin : g_bad_param
            $error("tick_debouncer: STABLE_TICKS must be >= 1");
        end
    endgenerate

    logic          sw_s;
    db_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rise_n;
`ifdef DB_FALL_TICK_EN
    logic          fall_n;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    // A mismatch on sw_s aborts the wait before any coincident tick is considered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
`ifdef DB_FALL_TICK_EN
        fall_n  = 1'b0;
`endif
        unique case (state)
            ZERO: begin
                if (sw_s) begin
                    state_n = WAIT1;
                    cnt_n   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_n = ZERO;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n = ONE;
                        cnt_n   = '0;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_n = WAIT0;
                    cnt_n   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_n = ONE;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_n = ZERO;
                        cnt_n   = '0;
`ifdef DB_FALL_TICK_EN
                        fall_n  = 1'b1;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ZERO;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
`ifdef DB_FALL_TICK_EN
            db_fall  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            db_level <= level_of(state_n);
            db_rise  <= rise_n;
`ifdef DB_FALL_TICK_EN
            db_fall  <= fall_n;
`endif
        end
    end

endmodule
